// File: rtl/clk_enable_gen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Provides the reconfiguration FSM states and an increment calculator for parameters.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SETTLE
    } fsm_state_e;

    // Rounded increment giving f_out from f_ref with a w-bit accumulator.
    function automatic longint unsigned freq_to_inc(
        input longint unsigned f_ref,
        input longint unsigned f_out,
        input int unsigned     w
    );
        longint unsigned scaled;
        scaled = f_out << w;
        return (scaled + (f_ref >> 1)) / f_ref;
    endfunction

endpackage

// File: rtl/clk_enable_gen_nco.sv
// One phase-accumulator channel: accumulator, increment register, load port,
// registered overflow pulse and divided square wave.
module clk_gen_nco #(
    parameter int unsigned      ACC_W       = 32,
    parameter logic [ACC_W-1:0] INC_DEFAULT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] load_phase,
    output logic             wrap,
    output logic             inc_zero,
    output logic             ce,
    output logic             sq
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             ce_q, ce_d;
    logic             sq_q, sq_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, inc_q};
        wrap     = sum[ACC_W];
        inc_zero = (inc_q == '0);
        acc_d    = sum[ACC_W-1:0];
        inc_d    = inc_q;
        ce_d     = wrap;
        sq_d     = sq_q ^ wrap;
        // A load still reports this edge's wrap on ce but restarts the square wave low.
        if (load) begin
            acc_d = load_phase;
            inc_d = load_inc;
            sq_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            inc_q <= INC_DEFAULT;
            ce_q  <= 1'b0;
            sq_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            inc_q <= inc_d;
            ce_q  <= ce_d;
            sq_q  <= sq_d;
        end
    end

    assign ce = ce_q;
    assign sq = sq_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator with glitch-free runtime
// increment reconfiguration and a settle/lock indicator.
module clk_enable_gen #(
    parameter int unsigned      NUM_CH      = 2,
    parameter int unsigned      ACC_W       = 32,
    parameter int unsigned      LOCK_CYCLES = 1024,
    parameter logic [ACC_W-1:0] INC_DEFAULT = 32'd2899102925
) (
    input  logic                                       refclk,
    input  logic                                       rst,
    input  logic                                       cfg_valid,
    output logic                                       cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]                           cfg_inc,
    input  logic [ACC_W-1:0]                           cfg_phase,
    output logic [NUM_CH-1:0]                          ce,
    output logic [NUM_CH-1:0]                          sq,
    output logic                                       locked
);

    import clk_gen_pkg::*;

    localparam int unsigned      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned      CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_CYCLES);

    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  cfg_ch_q, cfg_ch_d;
    logic [ACC_W-1:0] cfg_inc_q, cfg_inc_d;
    logic [ACC_W-1:0] cfg_phase_q, cfg_phase_d;

    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] inc_zero;
    logic [NUM_CH-1:0] apply;
    logic              tgt_go;

    // Target channel applies on its own wrap, or immediately if it can never wrap.
    always_comb begin
        tgt_go = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_ch_q == CH_W'(i)) begin
                tgt_go = wrap[i] | inc_zero[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_ch_d    = cfg_ch_q;
        cfg_inc_d   = cfg_inc_q;
        cfg_phase_d = cfg_phase_q;
        apply       = '0;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid && (32'(cfg_ch) < NUM_CH)) begin
                    cfg_ch_d    = cfg_ch;
                    cfg_inc_d   = cfg_inc;
                    cfg_phase_d = cfg_phase;
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (tgt_go) begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        apply[i] = (cfg_ch_q == CH_W'(i));
                    end
                    cnt_d   = CNT_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= SETTLE;
            cnt_q       <= CNT_INIT;
            cfg_ch_q    <= '0;
            cfg_inc_q   <= '0;
            cfg_phase_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_ch_q    <= cfg_ch_d;
            cfg_inc_q   <= cfg_inc_d;
            cfg_phase_q <= cfg_phase_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign locked    = (state_q != SETTLE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_gen_nco #(
            .ACC_W       (ACC_W),
            .INC_DEFAULT (INC_DEFAULT)
        ) u_nco (
            .clk        (refclk),
            .rst        (rst),
            .load       (apply[g]),
            .load_inc   (cfg_inc_q),
            .load_phase (cfg_phase_q),
            .wrap       (wrap[g]),
            .inc_zero   (inc_zero[g]),
            .ce         (ce[g]),
            .sq         (sq[g])
        );
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen (ACC_W=8, NUM_CH=2, LOCK_CYCLES=16, INC_DEFAULT=128),
// plus a 3-channel instance so an out-of-range channel index is representable.
module tb_clk_enable_gen;

    logic       refclk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_inc;
    logic [7:0] cfg_phase;
    logic [1:0] ce;
    logic [1:0] sq;
    logic       locked;

    logic       cfg3_valid;
    logic       cfg3_ready;
    logic [1:0] cfg3_ch;
    logic [7:0] cfg3_inc;
    logic [7:0] cfg3_phase;
    logic [2:0] ce3;
    logic [2:0] sq3;
    logic       locked3;

    int checks = 0;
    int errors = 0;

    clk_enable_gen #(
        .NUM_CH      (2),
        .ACC_W       (8),
        .LOCK_CYCLES (16),
        .INC_DEFAULT (8'd128)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .ce        (ce),
        .sq        (sq),
        .locked    (locked)
    );

    clk_enable_gen #(
        .NUM_CH      (3),
        .ACC_W       (8),
        .LOCK_CYCLES (16),
        .INC_DEFAULT (8'd128)
    ) dut3 (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg3_valid),
        .cfg_ready (cfg3_ready),
        .cfg_ch    (cfg3_ch),
        .cfg_inc   (cfg3_inc),
        .cfg_phase (cfg3_phase),
        .ce        (ce3),
        .sq        (sq3),
        .locked    (locked3)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance one active edge and settle just past it.
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    // Reset both instances and run 20 edges: default channels at acc=0, sq=0, locked.
    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg3_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
    endtask

    task automatic test_reset();
        logic [1:0] exp_ce;
        logic [1:0] exp_sq;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({ce, sq, locked, cfg_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: got ce=%b sq=%b locked=%b ready=%b, expected all 0",
                     ce, sq, locked, cfg_ready);
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_ce = (k % 2 == 0) ? 2'b11 : 2'b00;
            exp_sq = ((k / 2) % 2 == 1) ? 2'b11 : 2'b00;
            checks++;
            if (ce !== exp_ce || sq !== exp_sq) begin
                errors++;
                $display("FAIL reset_release_ce_sq k=%0d: got ce=%b sq=%b, expected ce=%b sq=%b",
                         k, ce, sq, exp_ce, exp_sq);
            end
            checks++;
            if (locked !== (k >= 16) || cfg_ready !== (k >= 16)) begin
                errors++;
                $display("FAIL reset_release_lock k=%0d: got locked=%b ready=%b, expected %b",
                         k, locked, cfg_ready, (k >= 16));
            end
        end
    endtask

    // Continues from edge 20 after test_reset; only dut3 is reconfigured.
    task automatic test_out_of_range();
        logic [2:0] exp_ce3;
        logic [2:0] exp_sq3;
        checks++;
        if (cfg3_ready !== 1'b1 || locked3 !== 1'b1) begin
            errors++;
            $display("FAIL oor_pre_idle: got ready=%b locked=%b, expected 1 1", cfg3_ready, locked3);
        end
        cfg3_valid = 1'b1;
        cfg3_ch = 2'd3;
        cfg3_inc = 8'd85;
        cfg3_phase = 8'h11;
        step();
        cfg3_valid = 1'b0;
        checks++;
        if (cfg3_ready !== 1'b1 || locked3 !== 1'b1 || ce3 !== 3'b000) begin
            errors++;
            $display("FAIL oor_accept: got ready=%b locked=%b ce=%b, expected 1 1 000",
                     cfg3_ready, locked3, ce3);
        end
        for (int k = 22; k <= 41; k++) begin
            step();
            exp_ce3 = (k % 2 == 0) ? 3'b111 : 3'b000;
            exp_sq3 = ((k / 2) % 2 == 1) ? 3'b111 : 3'b000;
            checks++;
            if (ce3 !== exp_ce3 || sq3 !== exp_sq3 || locked3 !== 1'b1) begin
                errors++;
                $display("FAIL oor_unchanged k=%0d: got ce=%b sq=%b locked=%b, expected ce=%b sq=%b locked=1",
                         k, ce3, sq3, locked3, exp_ce3, exp_sq3);
            end
        end
    endtask

    task automatic test_write_ch0();
        int cnt0;
        int cnt1;
        do_reset();
        cfg_valid = 1'b1;
        cfg_ch = 1'b0;
        cfg_inc = 8'd85;
        cfg_phase = 8'd0;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (locked !== 1'b1 || cfg_ready !== 1'b0 || ce !== 2'b00) begin
            errors++;
            $display("FAIL wr0_accept: got locked=%b ready=%b ce=%b, expected 1 0 00", locked, cfg_ready, ce);
        end
        step();
        checks++;
        if (ce !== 2'b11 || sq !== 2'b10 || locked !== 1'b0) begin
            errors++;
            $display("FAIL wr0_apply: got ce=%b sq=%b locked=%b, expected ce=11 sq=10 locked=0",
                     ce, sq, locked);
        end
        cnt0 = 0;
        cnt1 = 0;
        for (int j = 1; j <= 256; j++) begin
            step();
            if (ce[0]) cnt0++;
            if (ce[1]) cnt1++;
            checks++;
            if (locked !== (j >= 16)) begin
                errors++;
                $display("FAIL wr0_settle j=%0d: got locked=%b, expected %b", j, locked, (j >= 16));
            end
        end
        checks++;
        if (cnt0 < 84 || cnt0 > 86) begin
            errors++;
            $display("FAIL wr0_rate: got %0d ch0 pulses in 256 cycles, expected 85 +-1", cnt0);
        end
        checks++;
        if (cnt1 != 128) begin
            errors++;
            $display("FAIL wr0_ch1_rate: got %0d ch1 pulses in 256 cycles, expected 128", cnt1);
        end
    endtask

    task automatic test_inc_zero();
        do_reset();
        cfg_valid = 1'b1;
        cfg_ch = 1'b1;
        cfg_inc = 8'd0;
        cfg_phase = 8'h40;
        step();
        cfg_valid = 1'b0;
        step();
        checks++;
        if (ce !== 2'b11 || sq !== 2'b01 || locked !== 1'b0) begin
            errors++;
            $display("FAIL inc0_apply: got ce=%b sq=%b locked=%b, expected ce=11 sq=01 locked=0",
                     ce, sq, locked);
        end
        for (int k = 23; k <= 52; k++) begin
            step();
            checks++;
            if (ce[1] !== 1'b0 || sq[1] !== 1'b0) begin
                errors++;
                $display("FAIL inc0_silent k=%0d: got ce1=%b sq1=%b, expected 0 0", k, ce[1], sq[1]);
            end
        end
        // Channel 1 now has inc=0, so the next write applies on the edge after accept.
        cfg_valid = 1'b1;
        cfg_ch = 1'b1;
        cfg_inc = 8'd64;
        cfg_phase = 8'd0;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (locked !== 1'b1 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL inc0_accept: got locked=%b ready=%b, expected 1 0", locked, cfg_ready);
        end
        step();
        checks++;
        if (locked !== 1'b0 || ce[1] !== 1'b0 || sq[1] !== 1'b0) begin
            errors++;
            $display("FAIL inc0_immediate_apply: got locked=%b ce1=%b sq1=%b, expected 0 0 0",
                     locked, ce[1], sq[1]);
        end
        for (int j = 1; j <= 4; j++) begin
            step();
            checks++;
            if (ce[1] !== (j == 4) || sq[1] !== (j == 4)) begin
                errors++;
                $display("FAIL inc0_new_rate j=%0d: got ce1=%b sq1=%b, expected %b %b",
                         j, ce[1], sq[1], (j == 4), (j == 4));
            end
        end
    endtask

    task automatic test_same_cycle_wrap();
        do_reset();
        step();
        cfg_valid = 1'b1;
        cfg_ch = 1'b0;
        cfg_inc = 8'd85;
        cfg_phase = 8'd0;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (ce[0] !== 1'b1 || sq[0] !== 1'b1 || locked !== 1'b1 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL scw_accept_edge: got ce0=%b sq0=%b locked=%b ready=%b, expected 1 1 1 0",
                     ce[0], sq[0], locked, cfg_ready);
        end
        step();
        checks++;
        if (ce[0] !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL scw_wait: got ce0=%b locked=%b, expected 0 1", ce[0], locked);
        end
        step();
        checks++;
        if (ce[0] !== 1'b1 || sq[0] !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL scw_apply: got ce0=%b sq0=%b locked=%b, expected 1 0 0", ce[0], sq[0], locked);
        end
        for (int j = 1; j <= 4; j++) begin
            step();
            checks++;
            if (ce[0] !== (j == 4)) begin
                errors++;
                $display("FAIL scw_new_rate j=%0d: got ce0=%b, expected %b", j, ce[0], (j == 4));
            end
        end
    endtask

    task automatic test_rst_in_pend();
        logic [1:0] exp_ce;
        logic [1:0] exp_sq;
        do_reset();
        cfg_valid = 1'b1;
        cfg_ch = 1'b0;
        cfg_inc = 8'd85;
        cfg_phase = 8'h33;
        step();
        cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if ({ce, sq, locked, cfg_ready} !== 6'b0) begin
            errors++;
            $display("FAIL pend_rst_state: got ce=%b sq=%b locked=%b ready=%b, expected all 0",
                     ce, sq, locked, cfg_ready);
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_ce = (k % 2 == 0) ? 2'b11 : 2'b00;
            exp_sq = ((k / 2) % 2 == 1) ? 2'b11 : 2'b00;
            checks++;
            if (ce !== exp_ce || sq !== exp_sq || locked !== (k >= 16)) begin
                errors++;
                $display("FAIL pend_rst_restore k=%0d: got ce=%b sq=%b locked=%b, expected ce=%b sq=%b locked=%b",
                         k, ce, sq, locked, exp_ce, exp_sq, (k >= 16));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch = '0;
        cfg_inc = '0;
        cfg_phase = '0;
        cfg3_valid = 1'b0;
        cfg3_ch = '0;
        cfg3_inc = '0;
        cfg3_phase = '0;
        test_reset();
        test_out_of_range();
        test_write_ch0();
        test_inc_zero();
        test_same_cycle_wrap();
        test_rst_in_pend();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
